inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage for the TSC CPU. It owns the program counter, issues read requests to an external instruction memory over a ready handshake, and holds the fetched instruction stable for the decode/execute stage. The downstream stage consumes it through a valid/ack pair and returns a redirect target for jumps. The block also keeps the retired-instruction counter `num_inst` for simulation.

## Interface
Parameters:
- `WORD_SIZE`, 16: data, address and PC width.
- `RESET_PC`, 16'h0000: PC value loaded on reset.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_cpu`  in  1  reset, asynchronous, active-high.
- `cpu_enable`  in  1  when low, no new fetch starts and no instruction is accepted.
- `mem_read`  out  1  read request to instruction memory.
- `mem_addr`  out  WORD_SIZE  read address; equals the current PC.
- `mem_data`  in  WORD_SIZE  read data; valid in the cycle `mem_ready`=1.
- `mem_ready`  in  1  read complete; sampled only while `mem_read`=1.
- `inst`  out  WORD_SIZE  fetched instruction register.
- `inst_pc`  out  WORD_SIZE  address `inst` was fetched from.
- `inst_valid`  out  1  `inst`/`inst_pc` hold an unconsumed instruction.
- `inst_ack`  in  1  consumer accepts the current instruction.
- `redirect`  in  1  qualifies `inst_ack`; next PC = `redirect_target`.
- `redirect_target`  in  WORD_SIZE  full jump target, computed by the consumer.
- `num_inst`  out  WORD_SIZE  count of accepted instructions.
- `pc_below8bit`  out  8  `mem_addr[7:0]`, used by the LED output logic.

## Operation
- States: IDLE, FETCH, VALID. The state encoding is local to this block.
- Reset values (asynchronous):
  - state = IDLE, PC = `RESET_PC`.
  - `inst` = 0, `inst_pc` = 0, `inst_valid` = 0, `num_inst` = 0, `mem_read` = 0.
- IDLE: `mem_read`=0. Moves to FETCH on the first edge where `cpu_enable`=1.
- FETCH:
  - `mem_read`=1 and `mem_addr`=PC, both held constant until `mem_ready`.
  - On `mem_ready`=1: `inst` <= `mem_data`, `inst_pc` <= PC, go to VALID.
  - An outstanding request always completes, even if `cpu_enable` drops. `cpu_enable` is not sampled in FETCH.
- VALID:
  - `inst_valid`=1, `mem_read`=0; `inst`/`inst_pc` are held.
  - Acceptance is `inst_ack` & `cpu_enable`. On acceptance:
    - `num_inst` increments.
    - PC <= `redirect` ? `redirect_target` : `inst_pc`+1.
    - Go to FETCH.
  - Without acceptance, stay in VALID. `redirect` is ignored unless accepted.
- `mem_ready` outside FETCH and `inst_ack` outside VALID are ignored.
- Arithmetic: PC+1 and `num_inst`+1 are modulo 2^WORD_SIZE. 16'hFFFF wraps to 0 with no flag.
- `mem_addr` outputs the PC in every state. `pc_below8bit` therefore reflects the pending or next fetch address.

## Timing
- Zero-wait memory (`mem_ready`=1 in the same cycle as `mem_read`): FETCH entered at edge N gives `inst_valid`=1 after edge N+1.
- Maximum throughput is one instruction per 2 cycles with immediate ack.
- k wait cycles add k cycles. `mem_read`/`mem_addr` stay stable across all of them.
- After reset release with `cpu_enable`=1:
  - `mem_read` rises after the first edge.
  - The first instruction is valid after the second edge, for zero-wait memory.
- Acceptance and redirect take effect at the same edge. The next `mem_addr` shows the target immediately.
- Reset mid-FETCH or mid-VALID discards the request and the instruction, and returns to IDLE. The memory must tolerate a dropped `mem_read`.

## Structure
- `WORD_SIZE` and opcode/func constants come from the shared `opcodes.v` include. `inst_fetch` does not decode instructions.
- State encodings are localparams inside the block.
- No sub-module is required: one FSM, the PC register, the instruction register and the counter fit in one module.

## Test plan
- Reset, `cpu_enable`=1, zero-wait memory with mem[0]=16'h6000 -> `mem_read`=1 with `mem_addr`=0 after edge 1; `inst_valid`=1, `inst`=16'h6000, `inst_pc`=0 after edge 2.
- Ack without redirect at `inst_pc`=4 -> next `mem_addr`=5, `num_inst` increments by 1, `pc_below8bit`=8'h05.
- Ack with `redirect`=1, `redirect_target`=16'h0015 on JMP 16'h9015 -> next `mem_addr`=16'h0015, and addresses 17-20 are never requested.
- `mem_ready` delayed 3 cycles -> `mem_read`/`mem_addr` constant for 4 cycles, `inst_valid` rises only after `mem_ready`; with PC=16'hFFFF, ack -> next `mem_addr`=0.
- `inst_valid`=1, `inst_ack`=1, `cpu_enable`=0 for 5 cycles -> `inst`, PC and `num_inst` unchanged; raise `cpu_enable` -> accepted on that edge.
- Assert `reset_cpu` while in FETCH with `mem_addr`=9 -> `mem_read`, `inst_valid` and `num_inst` go to 0 immediately (asynchronously); after release, the first request is to address 0.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared word size and instruction-field constants for the TSC CPU front end.
// The fetch stage only uses the word size; the opcode fields are here for decode.
package inst_fetch_pkg;

  localparam int unsigned IF_WORD_SIZE = 16;
  localparam int unsigned IF_OPC_W     = 4;
  localparam int unsigned IF_FUNC_W    = 6;

  localparam logic [IF_OPC_W-1:0] OPC_RTYPE = 4'hF;
  localparam logic [IF_OPC_W-1:0] OPC_LHI   = 4'h6;
  localparam logic [IF_OPC_W-1:0] OPC_JMP   = 4'h9;
  localparam logic [IF_OPC_W-1:0] OPC_JAL   = 4'hA;

  localparam logic [IF_FUNC_W-1:0] FUNC_WWD = 6'd28;
  localparam logic [IF_FUNC_W-1:0] FUNC_HLT = 6'd29;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, fetches over a ready handshake and holds
// the fetched word for the consumer until it is accepted via inst_ack.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned          WORD_SIZE = IF_WORD_SIZE,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset_cpu,
  input  logic                 cpu_enable,
  output logic                 mem_read,
  output logic [WORD_SIZE-1:0] mem_addr,
  input  logic [WORD_SIZE-1:0] mem_data,
  input  logic                 mem_ready,
  output logic [WORD_SIZE-1:0] inst,
  output logic [WORD_SIZE-1:0] inst_pc,
  output logic                 inst_valid,
  input  logic                 inst_ack,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_target,
  output logic [WORD_SIZE-1:0] num_inst,
  output logic [7:0]           pc_below8bit
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } state_t;

  state_t               r_state;
  logic [WORD_SIZE-1:0] r_pc;
  logic [WORD_SIZE-1:0] r_inst;
  logic [WORD_SIZE-1:0] r_inst_pc;
  logic [WORD_SIZE-1:0] r_num_inst;
  logic                 r_inst_valid;
  logic                 r_mem_read;

  logic                 w_accept;
  logic [WORD_SIZE-1:0] w_pc_next;

  assign w_accept  = inst_ack & cpu_enable;
  // Fall-through address wraps silently at the top of the address space.
  assign w_pc_next = redirect ? redirect_target : (r_inst_pc + WORD_SIZE'(1));

  // Fetch FSM with PC, instruction register and retired counter.
  always_ff @(posedge clk or posedge reset_cpu) begin
    if (reset_cpu) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_num_inst   <= '0;
      r_inst_valid <= 1'b0;
      r_mem_read   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cpu_enable) begin
            r_state    <= ST_FETCH;
            r_mem_read <= 1'b1;
          end
        end
        // An issued request always completes; cpu_enable is not looked at here.
        ST_FETCH: begin
          if (mem_ready) begin
            r_inst       <= mem_data;
            r_inst_pc    <= r_pc;
            r_inst_valid <= 1'b1;
            r_mem_read   <= 1'b0;
            r_state      <= ST_VALID;
          end
        end
        ST_VALID: begin
          if (w_accept) begin
            r_num_inst   <= r_num_inst + WORD_SIZE'(1);
            r_pc         <= w_pc_next;
            r_inst_valid <= 1'b0;
            r_mem_read   <= 1'b1;
            r_state      <= ST_FETCH;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_inst_valid <= 1'b0;
          r_mem_read   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read     = r_mem_read;
  assign mem_addr     = r_pc;
  assign inst         = r_inst;
  assign inst_pc      = r_inst_pc;
  assign inst_valid   = r_inst_valid;
  assign num_inst     = r_num_inst;
  assign pc_below8bit = r_pc[7:0];

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: bench-owned memory with configurable wait states,
// a transaction-level model checked every cycle, and literal spot checks.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        reset_cpu;
  logic        cpu_enable;
  logic        mem_read;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_ready;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_valid;
  logic        inst_ack;
  logic        redirect;
  logic [15:0] redirect_target;
  logic [15:0] num_inst;
  logic [7:0]  pc_below8bit;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [0:65535];
  bit          requested [0:65535];
  int          wait_cfg;
  int          wait_cnt;

  inst_fetch #(.WORD_SIZE(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset_cpu(reset_cpu), .cpu_enable(cpu_enable),
    .mem_read(mem_read), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ready(mem_ready), .inst(inst), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .inst_ack(inst_ack), .redirect(redirect),
    .redirect_target(redirect_target), .num_inst(num_inst),
    .pc_below8bit(pc_below8bit)
  );

  always #5 clk = ~clk;

  // Memory: data is the word at the requested address, ready after wait_cfg cycles.
  assign mem_data  = mem[mem_addr];
  assign mem_ready = mem_read && (wait_cnt >= wait_cfg);

  always @(posedge clk or posedge reset_cpu) begin
    if (reset_cpu) wait_cnt <= 0;
    else if (!mem_read || mem_ready) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  always @(posedge clk) begin
    if (!reset_cpu && mem_read && mem_ready) requested[mem_addr] <= 1'b1;
  end

  // Transaction-level model: a request is outstanding, or a word is held, or neither.
  logic        m_busy, m_have;
  logic [15:0] m_pc, m_inst, m_ipc, m_count;

  always @(posedge clk or posedge reset_cpu) begin
    if (reset_cpu) begin
      m_busy <= 1'b0; m_have <= 1'b0;
      m_pc <= 16'h0000; m_inst <= 16'h0; m_ipc <= 16'h0; m_count <= 16'h0;
    end else if (m_busy) begin
      if (mem_ready) begin
        m_inst <= mem[m_pc]; m_ipc <= m_pc; m_have <= 1'b1; m_busy <= 1'b0;
      end
    end else if (m_have) begin
      if (inst_ack && cpu_enable) begin
        m_count <= m_count + 16'd1;
        m_pc    <= redirect ? redirect_target : m_ipc + 16'd1;
        m_have  <= 1'b0;
        m_busy  <= 1'b1;
      end
    end else if (cpu_enable) begin
      m_busy <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!reset_cpu) begin
      chk("model_mem_read",   32'(mem_read),     32'(m_busy));
      chk("model_mem_addr",   32'(mem_addr),     32'(m_pc));
      chk("model_valid",      32'(inst_valid),   32'(m_have));
      chk("model_inst",       32'(inst),         32'(m_inst));
      chk("model_inst_pc",    32'(inst_pc),      32'(m_ipc));
      chk("model_num_inst",   32'(num_inst),     32'(m_count));
      chk("model_pc_below8",  32'(pc_below8bit), 32'(m_pc[7:0]));
    end
  end

  task automatic wait_valid(input logic [15:0] pc);
    int n = 0;
    while (!(inst_valid && inst_pc == pc) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("wait_valid", {15'd0, inst_valid, inst_pc}, {15'd0, 1'b1, pc});
  endtask

  initial begin
    logic [15:0] saved;
    bit          skipped;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'h1000 + 16'(i);
      requested[i] = 1'b0;
    end
    mem[0]      = 16'h6000;
    mem[16]     = 16'h9015;
    mem[16'hFFFF] = 16'hABCD;
    reset_cpu = 1'b1; cpu_enable = 1'b1; inst_ack = 1'b0;
    redirect = 1'b0; redirect_target = 16'h0; wait_cfg = 0;

    repeat (2) @(negedge clk);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_valid",    32'(inst_valid), 32'd0);
    chk("rst_num",      32'(num_inst), 32'd0);
    chk("rst_inst",     32'(inst), 32'd0);
    chk("rst_addr",     32'(mem_addr), 32'd0);
    reset_cpu = 1'b0;

    // First fetch with zero-wait memory.
    @(negedge clk);
    chk("t1_read", 32'(mem_read), 32'd1);
    chk("t1_addr", 32'(mem_addr), 32'd0);
    chk("t1_notvalid", 32'(inst_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid", 32'(inst_valid), 32'd1);
    chk("t1_inst",  32'(inst), 32'h6000);
    chk("t1_ipc",   32'(inst_pc), 32'd0);

    // Sequential ack at inst_pc=4.
    inst_ack = 1'b1;
    wait_valid(16'd4);
    chk("t2_num_before", 32'(num_inst), 32'd4);
    @(negedge clk);
    chk("t2_addr", 32'(mem_addr), 32'd5);
    chk("t2_num",  32'(num_inst), 32'd5);
    chk("t2_pc8",  32'(pc_below8bit), 32'h05);

    // Jump redirect from address 16 to 0x15.
    wait_valid(16'd16);
    chk("t3_jmp_inst", 32'(inst), 32'h9015);
    redirect = 1'b1; redirect_target = 16'h0015;
    @(negedge clk);
    chk("t3_addr", 32'(mem_addr), 32'h0015);
    chk("t3_read", 32'(mem_read), 32'd1);
    redirect = 1'b0;
    wait_valid(16'd23);
    skipped = 1'b1;
    for (int a = 17; a <= 20; a++) if (requested[a]) skipped = 1'b0;
    chk("t3_skipped_17_20", 32'(skipped), 32'd1);
    chk("t3_req21", 32'(requested[21]), 32'd1);

    // Three wait states at PC=FFFF, then wrap to 0.
    redirect = 1'b1; redirect_target = 16'hFFFF; wait_cfg = 3;
    @(negedge clk);
    inst_ack = 1'b0; redirect = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("t4_read_held", 32'(mem_read), 32'd1);
      chk("t4_addr_held", 32'(mem_addr), 32'hFFFF);
      chk("t4_not_valid", 32'(inst_valid), 32'd0);
      @(negedge clk);
    end
    chk("t4_valid", 32'(inst_valid), 32'd1);
    chk("t4_inst",  32'(inst), 32'hABCD);
    chk("t4_ipc",   32'(inst_pc), 32'hFFFF);
    inst_ack = 1'b1; wait_cfg = 0;
    @(negedge clk);
    chk("t4_wrap_addr", 32'(mem_addr), 32'd0);
    chk("t4_wrap_pc8",  32'(pc_below8bit), 32'd0);
    chk("t4_num",       32'(num_inst), 32'd21);

    // Ack held while cpu_enable is low.
    inst_ack = 1'b0;
    @(negedge clk);
    chk("t5_valid", 32'(inst_valid), 32'd1);
    cpu_enable = 1'b0; inst_ack = 1'b1;
    saved = num_inst;
    repeat (5) begin
      @(negedge clk);
      chk("t5_hold_valid", 32'(inst_valid), 32'd1);
      chk("t5_hold_inst",  32'(inst), 32'h6000);
      chk("t5_hold_addr",  32'(mem_addr), 32'd0);
      chk("t5_hold_num",   32'(num_inst), 32'(saved));
    end
    cpu_enable = 1'b1;
    @(negedge clk);
    chk("t5_accept_num",  32'(num_inst), 32'd22);
    chk("t5_accept_addr", 32'(mem_addr), 32'd1);
    chk("t5_accept_read", 32'(mem_read), 32'd1);

    // Asynchronous reset in the middle of a fetch to address 9.
    inst_ack = 1'b0;
    wait_valid(16'd1);
    inst_ack = 1'b1; redirect = 1'b1; redirect_target = 16'd9; wait_cfg = 5;
    @(negedge clk);
    inst_ack = 1'b0; redirect = 1'b0;
    chk("t6_addr9", 32'(mem_addr), 32'd9);
    chk("t6_read9", 32'(mem_read), 32'd1);
    #2 reset_cpu = 1'b1;
    #1;
    chk("t6_async_read",  32'(mem_read), 32'd0);
    chk("t6_async_valid", 32'(inst_valid), 32'd0);
    chk("t6_async_num",   32'(num_inst), 32'd0);
    chk("t6_async_addr",  32'(mem_addr), 32'd0);
    @(negedge clk);
    reset_cpu = 1'b0; wait_cfg = 0;
    @(negedge clk);
    chk("t6_first_read", 32'(mem_read), 32'd1);
    chk("t6_first_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    chk("t6_first_inst", 32'(inst), 32'h6000);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
